// File: rtl/pbs_battle_datapath_if.sv
// Command strobes from the battle control FSM and status returned by the battle datapath.
// The FSM side uses the master modport; the datapath uses the slave modport.
interface pbs_battle_datapath_if #(
    parameter int unsigned HP_W = 8
);
    logic            load_ai_hp;
    logic            apply_ai_damage;
    logic            apply_p_damage;
    logic            apply_p_heal;
    logic            catch_try;
    logic            active_trainer;
    logic            target;
    logic [HP_W-1:0] p_hp;
    logic [HP_W-1:0] ai_hp;
    logic            p_dead;
    logic            ai_dead;
    logic            catch_done;
    logic            catch_success;
    logic            cmd_err;
    logic [7:0]      rnd;

    modport master (
        output load_ai_hp, apply_ai_damage, apply_p_damage, apply_p_heal, catch_try,
        output active_trainer, target,
        input  p_hp, ai_hp, p_dead, ai_dead, catch_done, catch_success, cmd_err, rnd
    );

    modport slave (
        input  load_ai_hp, apply_ai_damage, apply_p_damage, apply_p_heal, catch_try,
        input  active_trainer, target,
        output p_hp, ai_hp, p_dead, ai_dead, catch_done, catch_success, cmd_err, rnd
    );
endinterface

// File: rtl/pbs_battle_datapath.sv
// Battle datapath: HP registers, LFSR-randomised damage/heal/catch, and the death and
// catch status the battle FSM branches on. One command executes per cycle by priority.
module pbs_battle_datapath #(
    parameter int unsigned HP_W       = 8,
    parameter int unsigned P_MAX_HP   = 100,
    parameter int unsigned AI_MAX_HP  = 80,
    parameter int unsigned P_ATK      = 12,
    parameter int unsigned AI_ATK     = 10,
    parameter int unsigned HEAL_AMT   = 20,
    parameter int unsigned CATCH_BASE = 32,
    parameter logic [7:0]  SEED       = 8'hA5
) (
    input logic                  clk,
    input logic                  reset_n,
    pbs_battle_datapath_if.slave bus
);
    localparam int unsigned DW = HP_W + 2;
    localparam int unsigned TW = ((HP_W > 8) ? HP_W : 8) + 2;

    localparam logic [HP_W-1:0] P_MAX  = HP_W'(P_MAX_HP);
    localparam logic [HP_W-1:0] AI_MAX = HP_W'(AI_MAX_HP);

    logic [7:0]      lfsr_q, lfsr_d;
    logic [HP_W-1:0] p_hp_q, p_hp_d;
    logic [HP_W-1:0] ai_hp_q, ai_hp_d;
    logic            catch_pend_q, catch_pend_d;
    logic            catch_hit_q, catch_hit_d;
    logic            catch_done_q, catch_done_d;
    logic            catch_success_q, catch_success_d;
    logic            cmd_err_q, cmd_err_d;

    logic            p_dead, ai_dead, frozen;
    logic            ai_dmg_req, p_dmg_req, heal_req, catch_req;
    logic [2:0]      cmd_cnt;
    logic [DW-1:0]   ai_dmg, p_dmg;
    logic [HP_W:0]   heal_sum;
    logic [TW-1:0]   thresh_raw, thresh;
    logic            catch_roll;

    function automatic logic [DW-1:0] roll_dmg(input logic [DW-1:0] atk, input logic [7:0] r);
        logic [DW-1:0] d;
        d = atk + DW'(r[1:0]);
        if (r[7:6] == 2'b11) d = d << 1;
        return d;
    endfunction

    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                                input logic [DW-1:0]   d);
        if (DW'(hp) <= d) return '0;
        return hp - d[HP_W-1:0];
    endfunction

    assign p_dead  = (p_hp_q == '0);
    assign ai_dead = (ai_hp_q == '0);
    // Once the battle is decided only an AI reload is honoured, and nothing else counts as a clash.
    assign frozen  = p_dead | ai_dead | catch_success_q;

    assign ai_dmg_req = bus.apply_ai_damage & ~frozen;
    assign p_dmg_req  = bus.apply_p_damage & ~frozen;
    assign heal_req   = bus.apply_p_heal & ~frozen;
    assign catch_req  = bus.catch_try & ~frozen;
    assign cmd_cnt    = 3'(bus.load_ai_hp) + 3'(ai_dmg_req) + 3'(p_dmg_req) + 3'(heal_req)
                      + 3'(catch_req);

    assign ai_dmg     = roll_dmg(DW'(P_ATK), lfsr_q);
    assign p_dmg      = roll_dmg(DW'(AI_ATK), lfsr_q);
    assign heal_sum   = {1'b0, p_hp_q} + (HP_W + 1)'(HEAL_AMT);
    assign thresh_raw = TW'(CATCH_BASE) + TW'(AI_MAX_HP) - TW'(ai_hp_q);
    assign thresh     = (thresh_raw > TW'(255)) ? TW'(255) : thresh_raw;
    assign catch_roll = (TW'(lfsr_q) < thresh);

    always_comb begin
        lfsr_d          = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        p_hp_d          = p_hp_q;
        ai_hp_d         = ai_hp_q;
        catch_pend_d    = 1'b0;
        catch_hit_d     = 1'b0;
        catch_done_d    = catch_pend_q;
        catch_success_d = catch_success_q | (catch_pend_q & catch_hit_q);
        cmd_err_d       = (cmd_cnt > 3'd1);

        if (bus.load_ai_hp) begin
            ai_hp_d         = AI_MAX;
            catch_done_d    = 1'b0;
            catch_success_d = 1'b0;
        end else if (ai_dmg_req) begin
            if (!bus.active_trainer && bus.target) ai_hp_d = sat_sub(ai_hp_q, ai_dmg);
            else cmd_err_d = 1'b1;
        end else if (p_dmg_req) begin
            if (bus.active_trainer && !bus.target) p_hp_d = sat_sub(p_hp_q, p_dmg);
            else cmd_err_d = 1'b1;
        end else if (heal_req) begin
            p_hp_d = (heal_sum > (HP_W + 1)'(P_MAX_HP)) ? P_MAX : heal_sum[HP_W-1:0];
        end else if (catch_req) begin
            catch_pend_d = 1'b1;
            catch_hit_d  = catch_roll;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr_q          <= SEED;
            p_hp_q          <= P_MAX;
            ai_hp_q         <= AI_MAX;
            catch_pend_q    <= 1'b0;
            catch_hit_q     <= 1'b0;
            catch_done_q    <= 1'b0;
            catch_success_q <= 1'b0;
            cmd_err_q       <= 1'b0;
        end else begin
            lfsr_q          <= lfsr_d;
            p_hp_q          <= p_hp_d;
            ai_hp_q         <= ai_hp_d;
            catch_pend_q    <= catch_pend_d;
            catch_hit_q     <= catch_hit_d;
            catch_done_q    <= catch_done_d;
            catch_success_q <= catch_success_d;
            cmd_err_q       <= cmd_err_d;
        end
    end

    assign bus.p_hp          = p_hp_q;
    assign bus.ai_hp         = ai_hp_q;
    assign bus.p_dead        = p_dead;
    assign bus.ai_dead       = ai_dead;
    assign bus.catch_done    = catch_done_q;
    assign bus.catch_success = catch_success_q;
    assign bus.cmd_err       = cmd_err_q;
    assign bus.rnd           = lfsr_q;
endmodule

// File: tb/tb_pbs_battle_datapath.sv
// Directed bench for pbs_battle_datapath; LFSR values per edge after reset are
// A5 4A 95 2A 54 A9 53 A7 4E 9D 3B 77 EE DD, all expectations hand-derived from these.
module tb_pbs_battle_datapath;
    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    pbs_battle_datapath_if #(.HP_W(8)) bus ();

    pbs_battle_datapath dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic clear_cmds();
        bus.load_ai_hp      = 1'b0;
        bus.apply_ai_damage = 1'b0;
        bus.apply_p_damage  = 1'b0;
        bus.apply_p_heal    = 1'b0;
        bus.catch_try       = 1'b0;
        bus.active_trainer  = 1'b0;
        bus.target          = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one command set for exactly one rising edge; returns 1 time unit after it.
    task automatic drive(input logic ld, input logic aid, input logic pd, input logic hl,
                         input logic ct, input logic tr, input logic tg);
        bus.load_ai_hp      = ld;
        bus.apply_ai_damage = aid;
        bus.apply_p_damage  = pd;
        bus.apply_p_heal    = hl;
        bus.catch_try       = ct;
        bus.active_trainer  = tr;
        bus.target          = tg;
        tick(1);
        clear_cmds();
    endtask

    task automatic do_reset();
        clear_cmds();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.p_hp !== 8'd100) begin
            failures++; $display("FAIL reset_p_hp got=%0d exp=100", bus.p_hp);
        end
        checks++;
        if (bus.ai_hp !== 8'd80) begin
            failures++; $display("FAIL reset_ai_hp got=%0d exp=80", bus.ai_hp);
        end
        checks++;
        if (bus.rnd !== 8'hA5) begin
            failures++; $display("FAIL reset_rnd got=%h exp=a5", bus.rnd);
        end
        checks++;
        if ({bus.p_dead, bus.ai_dead, bus.catch_done, bus.catch_success, bus.cmd_err} !== 5'b0)
        begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {bus.p_dead, bus.ai_dead, bus.catch_done, bus.catch_success, bus.cmd_err});
        end
    endtask

    task automatic test_damage();
        do_reset();
        drive(0, 1, 0, 0, 0, 0, 1);  // E0 rnd A5: 12+1
        checks++;
        if (bus.ai_hp !== 8'd67) begin
            failures++; $display("FAIL dmg_ai_hp got=%0d exp=67", bus.ai_hp);
        end
        checks++;
        if (bus.rnd !== 8'h4A) begin
            failures++; $display("FAIL dmg_rnd1 got=%h exp=4a", bus.rnd);
        end
        checks++;
        if (bus.cmd_err !== 1'b0) begin
            failures++; $display("FAIL dmg_cmd_err got=%b exp=0", bus.cmd_err);
        end
        drive(0, 0, 1, 0, 0, 1, 0);  // E1 rnd 4A: 10+2
        checks++;
        if (bus.p_hp !== 8'd88) begin
            failures++; $display("FAIL dmg_p_hp got=%0d exp=88", bus.p_hp);
        end
        checks++;
        if (bus.rnd !== 8'h95) begin
            failures++; $display("FAIL dmg_rnd2 got=%h exp=95", bus.rnd);
        end
        tick(10);
        checks++;
        if (bus.rnd !== 8'hEE) begin
            failures++; $display("FAIL dmg_rnd12 got=%h exp=ee", bus.rnd);
        end
        drive(0, 1, 0, 0, 0, 0, 1);  // E12 rnd EE: crit (12+2)*2
        checks++;
        if (bus.ai_hp !== 8'd39) begin
            failures++; $display("FAIL dmg_crit_ai_hp got=%0d exp=39", bus.ai_hp);
        end
    endtask

    task automatic test_heal();
        do_reset();
        drive(0, 0, 0, 1, 0, 0, 0);  // E0 heal at full
        checks++;
        if (bus.p_hp !== 8'd100) begin
            failures++; $display("FAIL heal_full got=%0d exp=100", bus.p_hp);
        end
        drive(0, 0, 1, 0, 0, 1, 0);  // E1 rnd 4A: 12
        drive(0, 0, 0, 1, 0, 0, 0);  // E2 88+20 capped
        checks++;
        if (bus.p_hp !== 8'd100) begin
            failures++; $display("FAIL heal_cap got=%0d exp=100", bus.p_hp);
        end
        drive(0, 0, 1, 0, 0, 1, 0);  // E3 rnd 2A: 12
        drive(0, 0, 1, 0, 0, 1, 0);  // E4 rnd 54: 10
        checks++;
        if (bus.p_hp !== 8'd78) begin
            failures++; $display("FAIL heal_pre got=%0d exp=78", bus.p_hp);
        end
        drive(0, 0, 0, 1, 0, 0, 0);  // E5 78+20
        checks++;
        if (bus.p_hp !== 8'd98) begin
            failures++; $display("FAIL heal_add got=%0d exp=98", bus.p_hp);
        end
    endtask

    task automatic test_dead();
        do_reset();
        repeat (6) drive(0, 1, 0, 0, 0, 0, 1);  // 13,14,13,14,12,13
        checks++;
        if (bus.ai_hp !== 8'd1) begin
            failures++; $display("FAIL dead_pre got=%0d exp=1", bus.ai_hp);
        end
        drive(0, 1, 0, 0, 0, 0, 1);  // E6 rnd 53: 15, saturates
        checks++;
        if (bus.ai_hp !== 8'd0 || bus.ai_dead !== 1'b1) begin
            failures++;
            $display("FAIL dead_sat got=%0d/%b exp=0/1", bus.ai_hp, bus.ai_dead);
        end
        drive(0, 0, 1, 0, 0, 1, 0);
        checks++;
        if (bus.p_hp !== 8'd100 || bus.cmd_err !== 1'b0) begin
            failures++;
            $display("FAIL dead_freeze got=%0d/%b exp=100/0", bus.p_hp, bus.cmd_err);
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        tick(1);
        checks++;
        if (bus.catch_done !== 1'b0) begin
            failures++; $display("FAIL dead_catch got=%b exp=0", bus.catch_done);
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.ai_hp !== 8'd80 || bus.ai_dead !== 1'b0) begin
            failures++;
            $display("FAIL dead_reload got=%0d/%b exp=80/0", bus.ai_hp, bus.ai_dead);
        end
    endtask

    task automatic test_catch();
        do_reset();
        drive(0, 0, 0, 0, 1, 0, 0);  // E0 rnd A5=165 vs 32
        checks++;
        if (bus.catch_done !== 1'b0) begin
            failures++; $display("FAIL catch_lat got=%b exp=0", bus.catch_done);
        end
        drive(0, 0, 0, 0, 1, 0, 0);  // E1 rnd 4A=74 vs 32
        checks++;
        if (bus.catch_done !== 1'b1 || bus.catch_success !== 1'b0) begin
            failures++;
            $display("FAIL catch_miss1 got=%b/%b exp=1/0", bus.catch_done, bus.catch_success);
        end
        tick(1);
        checks++;
        if (bus.catch_done !== 1'b1 || bus.catch_success !== 1'b0) begin
            failures++;
            $display("FAIL catch_miss2 got=%b/%b exp=1/0", bus.catch_done, bus.catch_success);
        end
        repeat (5) drive(0, 1, 0, 0, 0, 0, 1);  // E3..E7: 14,12,13,15,15
        checks++;
        if (bus.ai_hp !== 8'd11 || bus.catch_done !== 1'b0) begin
            failures++;
            $display("FAIL catch_pre got=%0d/%b exp=11/0", bus.ai_hp, bus.catch_done);
        end
        drive(0, 0, 0, 0, 1, 0, 0);  // E8 rnd 4E=78 vs 101
        checks++;
        if (bus.catch_done !== 1'b0 || bus.catch_success !== 1'b0) begin
            failures++;
            $display("FAIL catch_hit_lat got=%b/%b exp=0/0", bus.catch_done, bus.catch_success);
        end
        tick(1);
        checks++;
        if (bus.catch_done !== 1'b1 || bus.catch_success !== 1'b1) begin
            failures++;
            $display("FAIL catch_hit got=%b/%b exp=1/1", bus.catch_done, bus.catch_success);
        end
        tick(1);
        checks++;
        if (bus.catch_done !== 1'b0 || bus.catch_success !== 1'b1) begin
            failures++;
            $display("FAIL catch_hold got=%b/%b exp=0/1", bus.catch_done, bus.catch_success);
        end
        drive(0, 1, 0, 0, 0, 0, 1);
        checks++;
        if (bus.ai_hp !== 8'd11 || bus.cmd_err !== 1'b0) begin
            failures++;
            $display("FAIL catch_freeze got=%0d/%b exp=11/0", bus.ai_hp, bus.cmd_err);
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        tick(1);
        checks++;
        if (bus.catch_done !== 1'b0) begin
            failures++; $display("FAIL catch_frozen_try got=%b exp=0", bus.catch_done);
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.ai_hp !== 8'd80 || bus.catch_success !== 1'b0) begin
            failures++;
            $display("FAIL catch_reload got=%0d/%b exp=80/0", bus.ai_hp, bus.catch_success);
        end
    endtask

    task automatic test_priority();
        do_reset();
        drive(0, 0, 1, 0, 0, 1, 0);  // E0 rnd A5: 10+1
        drive(0, 1, 0, 1, 0, 0, 1);  // E1 damage beats heal, rnd 4A: 14
        checks++;
        if (bus.ai_hp !== 8'd66 || bus.p_hp !== 8'd89) begin
            failures++;
            $display("FAIL prio_hp got=%0d/%0d exp=66/89", bus.ai_hp, bus.p_hp);
        end
        checks++;
        if (bus.cmd_err !== 1'b1) begin
            failures++; $display("FAIL prio_err got=%b exp=1", bus.cmd_err);
        end
        tick(1);
        checks++;
        if (bus.cmd_err !== 1'b0) begin
            failures++; $display("FAIL prio_err_pulse got=%b exp=0", bus.cmd_err);
        end
        drive(0, 1, 0, 0, 0, 0, 0);  // wrong target
        checks++;
        if (bus.ai_hp !== 8'd66 || bus.cmd_err !== 1'b1) begin
            failures++;
            $display("FAIL bad_target got=%0d/%b exp=66/1", bus.ai_hp, bus.cmd_err);
        end
        drive(0, 0, 1, 0, 0, 0, 0);  // wrong trainer
        checks++;
        if (bus.p_hp !== 8'd89 || bus.cmd_err !== 1'b1) begin
            failures++;
            $display("FAIL bad_trainer got=%0d/%b exp=89/1", bus.p_hp, bus.cmd_err);
        end
        drive(1, 0, 0, 0, 1, 0, 0);  // reload beats catch
        checks++;
        if (bus.ai_hp !== 8'd80 || bus.cmd_err !== 1'b1) begin
            failures++;
            $display("FAIL prio_load got=%0d/%b exp=80/1", bus.ai_hp, bus.cmd_err);
        end
        tick(1);
        checks++;
        if (bus.catch_done !== 1'b0) begin
            failures++; $display("FAIL prio_catch_drop got=%b exp=0", bus.catch_done);
        end
    endtask

    task automatic test_reset_midcatch();
        do_reset();
        drive(0, 1, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 0);
        reset_n = 1'b0;
        tick(1);
        checks++;
        if (bus.catch_done !== 1'b0) begin
            failures++; $display("FAIL rst_catch_done got=%b exp=0", bus.catch_done);
        end
        checks++;
        if (bus.ai_hp !== 8'd80 || bus.p_hp !== 8'd100 || bus.rnd !== 8'hA5) begin
            failures++;
            $display("FAIL rst_values got=%0d/%0d/%h exp=80/100/a5", bus.ai_hp, bus.p_hp,
                     bus.rnd);
        end
        tick(1);
        reset_n = 1'b1;
        checks++;
        if ({bus.catch_done, bus.catch_success, bus.cmd_err} !== 3'b0) begin
            failures++;
            $display("FAIL rst_flags got=%b exp=000",
                     {bus.catch_done, bus.catch_success, bus.cmd_err});
        end
        tick(2);
        checks++;
        if (bus.catch_done !== 1'b0) begin
            failures++; $display("FAIL rst_no_late_done got=%b exp=0", bus.catch_done);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        reset_n  = 1'b0;
        clear_cmds();
        test_reset();
        test_damage();
        test_heal();
        test_dead();
        test_catch();
        test_priority();
        test_reset_midcatch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
